timer_counter: RTL and testbench

Counting core of the APB timer. Consumes the `timer_en`, `div_en` and `div_val` fields from the timer control register. Implements the clock prescaler, the 64-bit up-counter, the 64-bit compare register and the interrupt enable/status registers. Register writes arrive on the same decoded `addr`/`wr_en`/`wdata` bus as the control register. Register contents are exported for the bus read mux.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_prescaler.sv | 49 ++++
 rtl/timer_counter.sv | 94 +++++++++
 tb/tb_timer_counter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the APB timer: register offsets, compare reset value
// and the largest accepted prescaler exponent.
package timer_pkg;

  localparam logic [31:0] TCR_OFS   = 32'h00;
  localparam logic [31:0] TDR0_OFS  = 32'h04;
  localparam logic [31:0] TDR1_OFS  = 32'h08;
  localparam logic [31:0] TCMP0_OFS = 32'h0C;
  localparam logic [31:0] TCMP1_OFS = 32'h10;
  localparam logic [31:0] TIER_OFS  = 32'h14;
  localparam logic [31:0] TISR_OFS  = 32'h18;

  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int DIV_MAX = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: produces a one-cycle tick every 2^div_val cycles while
// the timer runs, or every cycle when the prescaler is bypassed.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_MAX = timer_pkg::DIV_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timer_en,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  localparam logic [3:0] DIV_LIM = 4'(DIV_MAX);

  logic [7:0] div_cnt;
  logic [3:0] div_val_q;
  logic       div_en_q;
  logic [3:0] div_exp;
  logic [7:0] div_term;
  logic       cfg_change;

  always_comb begin
    div_exp    = (div_val > DIV_LIM) ? DIV_LIM : div_val;
    div_term   = 8'((9'd1 << div_exp) - 9'd1);
    cfg_change = (div_val != div_val_q) || (div_en != div_en_q);
    tick       = timer_en && (!div_en || (div_cnt == div_term));
  end

  // A configuration change restarts the divide period so a shrinking
  // exponent never leaves div_cnt stranded above the new terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= 8'd0;
      div_val_q <= 4'd0;
      div_en_q  <= 1'b0;
    end else begin
      div_val_q <= div_val;
      div_en_q  <= div_en;
      if (!timer_en || !div_en || cfg_change || tick)
        div_cnt <= 8'd0;
      else
        div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Timer counting core: 64-bit counter, 64-bit compare, and the sticky
// compare interrupt with its enable, all exported for the bus read mux.
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          DIV_MAX   = timer_pkg::DIV_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  output logic [31:0] tdr0,
  output logic [31:0] tdr1,
  output logic [31:0] tcmp0,
  output logic [31:0] tcmp1,
  output logic [31:0] tier,
  output logic [31:0] tisr,
  output logic        tim_int
);

  logic        tick;
  logic [63:0] cnt;
  logic [63:0] cnt_next;
  logic [63:0] cmp;
  logic        int_en;
  logic        int_st;
  logic        match;
  logic        wr_tdr0, wr_tdr1, wr_tcmp0, wr_tcmp1, wr_tier, wr_tisr;

  timer_prescaler #(
    .DIV_MAX(DIV_MAX)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .timer_en(timer_en),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

  always_comb begin
    wr_tdr0  = wr_en && (addr == BASE_ADDR + TDR0_OFS);
    wr_tdr1  = wr_en && (addr == BASE_ADDR + TDR1_OFS);
    wr_tcmp0 = wr_en && (addr == BASE_ADDR + TCMP0_OFS);
    wr_tcmp1 = wr_en && (addr == BASE_ADDR + TCMP1_OFS);
    wr_tier  = wr_en && (addr == BASE_ADDR + TIER_OFS);
    wr_tisr  = wr_en && (addr == BASE_ADDR + TISR_OFS);
    match    = (cnt == cmp);
  end

  // A bus write to either half suppresses that cycle's increment entirely.
  always_comb begin
    cnt_next = cnt;
    if (wr_tdr0)
      cnt_next[31:0] = wdata;
    else if (wr_tdr1)
      cnt_next[63:32] = wdata;
    else if (tick)
      cnt_next = cnt + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 64'd0;
      cmp    <= CMP_RST;
      int_en <= 1'b0;
      int_st <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (wr_tcmp0) cmp[31:0]  <= wdata;
      if (wr_tcmp1) cmp[63:32] <= wdata;
      if (wr_tier)  int_en     <= wdata[0];
      // Set has priority so a match coinciding with a clear is never lost.
      if (match)
        int_st <= 1'b1;
      else if (wr_tisr && wdata[0])
        int_st <= 1'b0;
    end
  end

  assign tdr0    = cnt[31:0];
  assign tdr1    = cnt[63:32];
  assign tcmp0   = cmp[31:0];
  assign tcmp1   = cmp[63:32];
  assign tier    = {31'h0, int_en};
  assign tisr    = {31'h0, int_st};
  assign tim_int = int_en & int_st;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: one task per scenario,
// each with inline comparisons against hand-computed values.
module tb_timer_counter;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic [31:0] tdr0, tdr1, tcmp0, tcmp1, tier, tisr;
  logic        tim_int;

  int errors = 0;
  int checks = 0;

  timer_counter #(
    .BASE_ADDR(BASE),
    .DIV_MAX  (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .timer_en(timer_en),
    .div_en  (div_en),
    .div_val (div_val),
    .tdr0    (tdr0),
    .tdr1    (tdr1),
    .tcmp0   (tcmp0),
    .tcmp1   (tcmp1),
    .tier    (tier),
    .tisr    (tisr),
    .tim_int (tim_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] ofs, input logic [31:0] d);
    addr  = BASE + ofs;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; addr = 32'h0; wr_en = 1'b0; wdata = 32'h0;
    timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0;
    step(2);
    checks++;
    if ({tdr1, tdr0} !== 64'd0) begin
      errors++; $display("FAIL reset_cnt: got %h expected 0", {tdr1, tdr0});
    end
    checks++;
    if ({tcmp1, tcmp0} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL reset_cmp: got %h expected ffffffffffffffff", {tcmp1, tcmp0});
    end
    checks++;
    if (tier !== 32'd0 || tisr !== 32'd0 || tim_int !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got tier=%h tisr=%h int=%b expected 0/0/0", tier, tisr, tim_int);
    end
    rst_n = 1'b1;
    step(1);
    $display("test_reset done");
  endtask

  task automatic test_free_run;
    timer_en = 1'b1; div_en = 1'b0;
    step(10);
    timer_en = 1'b0;
    checks++;
    if (tdr0 !== 32'd10 || tdr1 !== 32'd0) begin
      errors++; $display("FAIL free_run: got %h_%h expected 0_a", tdr1, tdr0);
    end
    $display("test_free_run tdr0=%0d", tdr0);
  endtask

  task automatic test_prescale;
    div_en = 1'b1; div_val = 4'd3;
    bus_wr(TDR0_OFS, 32'd0);
    timer_en = 1'b1;
    step(63);
    checks++;
    if (tdr0 !== 32'd7) begin
      errors++; $display("FAIL prescale_63: got %0d expected 7", tdr0);
    end
    step(1);
    checks++;
    if (tdr0 !== 32'd8) begin
      errors++; $display("FAIL prescale_64: got %0d expected 8", tdr0);
    end
    step(3);
    div_val = 4'd0;
    step(1);
    checks++;
    if (tdr0 !== 32'd8) begin
      errors++; $display("FAIL prescale_chg1: got %0d expected 8", tdr0);
    end
    step(1);
    checks++;
    if (tdr0 !== 32'd9) begin
      errors++; $display("FAIL prescale_chg2: got %0d expected 9", tdr0);
    end
    step(1);
    checks++;
    if (tdr0 !== 32'd10) begin
      errors++; $display("FAIL prescale_chg3: got %0d expected 10", tdr0);
    end
    timer_en = 1'b0; div_en = 1'b0;
    step(1);
    $display("test_prescale tdr0=%0d", tdr0);
  endtask

  task automatic test_carry_wrap;
    bus_wr(TDR0_OFS, 32'hFFFF_FFFF);
    bus_wr(TDR1_OFS, 32'h0);
    timer_en = 1'b1;
    step(1);
    timer_en = 1'b0;
    checks++;
    if (tdr0 !== 32'd0 || tdr1 !== 32'd1) begin
      errors++; $display("FAIL carry: got %h_%h expected 00000001_00000000", tdr1, tdr0);
    end
    bus_wr(TDR0_OFS, 32'hFFFF_FFFF);
    bus_wr(TDR1_OFS, 32'hFFFF_FFFF);
    timer_en = 1'b1;
    step(1);
    timer_en = 1'b0;
    checks++;
    if (tdr0 !== 32'd0 || tdr1 !== 32'd0) begin
      errors++; $display("FAIL wrap: got %h_%h expected 0_0", tdr1, tdr0);
    end
    // Counter sat on the all-ones reset compare value for one cycle.
    checks++;
    if (tisr !== 32'd1 || tim_int !== 1'b0) begin
      errors++; $display("FAIL wrap_match: got tisr=%h int=%b expected 1/0", tisr, tim_int);
    end
    $display("test_carry_wrap tdr=%h_%h", tdr1, tdr0);
  endtask

  task automatic test_write_vs_inc;
    timer_en = 1'b1;
    bus_wr(TDR0_OFS, 32'h100);
    checks++;
    if (tdr0 !== 32'h100) begin
      errors++; $display("FAIL wr_priority: got %h expected 100", tdr0);
    end
    step(1);
    timer_en = 1'b0;
    checks++;
    if (tdr0 !== 32'h101) begin
      errors++; $display("FAIL wr_then_inc: got %h expected 101", tdr0);
    end
    $display("test_write_vs_inc tdr0=%h", tdr0);
  endtask

  task automatic test_addr_decode;
    bus_wr(32'h1C, 32'hDEAD_BEEF);
    bus_wr(TCR_OFS, 32'h0000_0055);
    bus_wr(32'h1000_0004, 32'h1234_5678);
    bus_wr(32'h1000_000C, 32'h1234_5678);
    checks++;
    if (tdr0 !== 32'h101 || tdr1 !== 32'h0) begin
      errors++; $display("FAIL decode_cnt: got %h_%h expected 0_101", tdr1, tdr0);
    end
    checks++;
    if (tcmp0 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL decode_cmp: got %h expected ffffffff", tcmp0);
    end
    $display("test_addr_decode tdr0=%h tcmp0=%h", tdr0, tcmp0);
  endtask

  task automatic test_compare_irq;
    bus_wr(TDR0_OFS, 32'd0);
    bus_wr(TDR1_OFS, 32'd0);
    bus_wr(TCMP0_OFS, 32'd20);
    bus_wr(TCMP1_OFS, 32'd0);
    bus_wr(TIER_OFS, 32'd1);
    bus_wr(TISR_OFS, 32'd1);
    checks++;
    if (tisr !== 32'd0 || tim_int !== 1'b0 || tier !== 32'd1 || tcmp0 !== 32'd20) begin
      errors++; $display("FAIL irq_setup: got tisr=%h int=%b tier=%h tcmp0=%h expected 0/0/1/14", tisr, tim_int, tier, tcmp0);
    end
    timer_en = 1'b1;
    step(20);
    checks++;
    if (tdr0 !== 32'd20 || tisr !== 32'd0) begin
      errors++; $display("FAIL irq_at_match: got tdr0=%0d tisr=%h expected 20/0", tdr0, tisr);
    end
    step(1);
    checks++;
    if (tdr0 !== 32'd21 || tisr !== 32'd1 || tim_int !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got tdr0=%0d tisr=%h int=%b expected 21/1/1", tdr0, tisr, tim_int);
    end
    step(2);
    bus_wr(TISR_OFS, 32'd1);
    timer_en = 1'b0;
    checks++;
    if (tisr !== 32'd0 || tim_int !== 1'b0) begin
      errors++; $display("FAIL irq_clear: got tisr=%h int=%b expected 0/0", tisr, tim_int);
    end
    bus_wr(TDR0_OFS, 32'd20);
    bus_wr(TISR_OFS, 32'd1);
    checks++;
    if (tisr !== 32'd1) begin
      errors++; $display("FAIL set_beats_clear: got tisr=%h expected 1", tisr);
    end
    bus_wr(TIER_OFS, 32'd0);
    checks++;
    if (tim_int !== 1'b0 || tier !== 32'd0) begin
      errors++; $display("FAIL irq_disable: got int=%b tier=%h expected 0/0", tim_int, tier);
    end
    bus_wr(TIER_OFS, 32'd1);
    checks++;
    if (tim_int !== 1'b1) begin
      errors++; $display("FAIL irq_late_enable: got int=%b expected 1", tim_int);
    end
    $display("test_compare_irq tisr=%h tim_int=%b", tisr, tim_int);
  endtask

  task automatic test_reset_mid;
    bus_wr(TDR0_OFS, 32'd55);
    bus_wr(TCMP0_OFS, 32'd55);
    step(1);
    checks++;
    if (tdr0 !== 32'd55 || tisr !== 32'd1) begin
      errors++; $display("FAIL pre_reset: got tdr0=%0d tisr=%h expected 55/1", tdr0, tisr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tdr0 !== 32'd0 || tdr1 !== 32'd0 || tier !== 32'd0 || tisr !== 32'd0 || tim_int !== 1'b0) begin
      errors++; $display("FAIL async_reset: got tdr=%h_%h tier=%h tisr=%h int=%b expected all 0", tdr1, tdr0, tier, tisr, tim_int);
    end
    checks++;
    if (tcmp0 !== 32'hFFFF_FFFF || tcmp1 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL async_reset_cmp: got %h_%h expected ffffffff_ffffffff", tcmp1, tcmp0);
    end
    timer_en = 1'b1;
    step(2);
    checks++;
    if (tdr0 !== 32'd0) begin
      errors++; $display("FAIL held_in_reset: got %0d expected 0", tdr0);
    end
    rst_n = 1'b1;
    step(3);
    timer_en = 1'b0;
    checks++;
    if (tdr0 !== 32'd3) begin
      errors++; $display("FAIL resume: got %0d expected 3", tdr0);
    end
    $display("test_reset_mid tdr0=%0d", tdr0);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescale();
    test_carry_wrap();
    test_write_vs_inc();
    test_addr_decode();
    test_compare_irq();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
